// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shifter.
//   shift_state_t : controller states (IDLE, SHIFT, DONE)
//   DIR_LEFT      : dir encoding for a logical left shift
//   DIR_RIGHT     : dir encoding for a logical right shift
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_seq_if.sv
// Request/result bundle of the sequential shifter.
//   start : request, only looked at while the shifter is idle
//   dir   : 0 = logical left, 1 = logical right (zero fill)
//   a     : operand, captured with start
//   amt   : shift amount, captured with start
//   busy  : request in progress
//   done  : one-cycle pulse, y holds the result
//   y     : result register, held until the next accepted start
//
// Handshake: a request is accepted on the rising edge where start is high
// and the shifter is idle (busy low); a, dir and amt are sampled on that
// same edge only. The requester may then change or drop its inputs
// freely. start while busy is neither queued nor applied. Completion is
// the single cycle where done is high; there is no back-pressure on done.
interface shift_seq_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) ();

  logic             start;
  logic             dir;
  logic [WIDTH-1:0] a;
  logic [AMT_W-1:0] amt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;

  modport master (
    output start, dir, a, amt,
    input  busy, done, y
  );

  modport slave (
    input  start, dir, a, amt,
    output busy, done, y
  );

endinterface

// File: rtl/shift1.sv
// One-position combinational shifter with zero fill.
//   dir : 0 = left by one, 1 = right by one
//   a   : operand
//   y   : a shifted by one position
module shift1
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             dir,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = (dir == DIR_RIGHT) ? {1'b0, a[WIDTH-1:1]} : {a[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/shift_seq.sv
// Sequential multi-position shifter: captures an operand, direction and
// amount, then runs its working register through shift1 once per clock
// until the amount is used up, and presents the result with a done pulse.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : request/result bundle (slave side)
//   dbg_state : current controller state, for observation only
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  shift_seq_if.slave   bus,
  output shift_state_t dbg_state
);

  shift_state_t     state_r, state_next;
  logic [WIDTH-1:0] data_r, data_next;
  logic             dir_r, dir_next;
  logic [AMT_W-1:0] cnt_r, cnt_next;
  logic [WIDTH-1:0] y_r, y_next;
  logic [WIDTH-1:0] shifted;

  shift1 #(
    .WIDTH (WIDTH)
  ) u_shift1 (
    .dir (dir_r),
    .a   (data_r),
    .y   (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      data_r  <= '0;
      dir_r   <= 1'b0;
      cnt_r   <= '0;
      y_r     <= '0;
    end else begin
      state_r <= state_next;
      data_r  <= data_next;
      dir_r   <= dir_next;
      cnt_r   <= cnt_next;
      y_r     <= y_next;
    end
  end

  // y is loaded on the edge that enters DONE, so the result is already
  // visible in the cycle where done is high. The value loaded is whatever
  // data_r becomes on that same edge.
  always_comb begin
    state_next = state_r;
    data_next  = data_r;
    dir_next   = dir_r;
    cnt_next   = cnt_r;
    y_next     = y_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          data_next = bus.a;
          dir_next  = bus.dir;
          cnt_next  = bus.amt;
          if (bus.amt == '0) begin
            state_next = DONE;
            y_next     = bus.a;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_next = shifted;
        cnt_next  = cnt_r - AMT_W'(1);
        if (cnt_r == AMT_W'(1)) begin
          state_next = DONE;
          y_next     = shifted;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Both status outputs are pure state decodes.
  assign bus.busy  = (state_r == SHIFT) || (state_r == DONE);
  assign bus.done  = (state_r == DONE);
  assign bus.y     = y_r;
  assign dbg_state = state_r;

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;
  import shift_pkg::*;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;
  localparam int MAX_WAIT = 40;

  logic         clk;
  logic         rst_n;
  shift_state_t dbg_state;

  shift_seq_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  shift_seq #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver: one request, optional ignored start pulse at cycle 'glitch'
  // after acceptance (0 = none). Expected result and latency supplied by caller.
  task automatic run_req(input string name, input logic [7:0] a, input logic dir,
                         input logic [2:0] amt, input logic [7:0] exp_y,
                         input int exp_lat, input int glitch);
    int lat;
    int extra_done;
    logic [7:0] want;
    exp_q.push_back(exp_y);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.dir = dir; bus.amt = amt;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 8'($urandom_range(0, 255));
    bus.dir = ~dir;
    bus.amt = 3'($urandom_range(0, 7));
    lat = 1;
    while (!bus.done && lat < MAX_WAIT) begin
      check({name, "_busy"}, 32'(bus.busy), 32'd1);
      if (lat == glitch) begin
        bus.start = 1'b1; bus.a = 8'h0F; bus.dir = 1'b1; bus.amt = 3'd0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    want = exp_q.pop_front();
    if (!bus.done) begin
      check({name, "_timeout"}, 32'(bus.done), 32'd1);
    end else begin
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
      check({name, "_busy_done"}, 32'(bus.busy), 32'd1);
      check({name, "_y"}, 32'(bus.y), 32'(want));
      @(negedge clk);
      check({name, "_done_fall"}, 32'(bus.done), 32'd0);
      check({name, "_busy_fall"}, 32'(bus.busy), 32'd0);
      check({name, "_y_hold"}, 32'(bus.y), 32'(want));
      if (glitch != 0) begin
        extra_done = 0;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          if (bus.done) extra_done++;
        end
        check({name, "_no_second_done"}, 32'(extra_done), 32'd0);
        check({name, "_y_after"}, 32'(bus.y), 32'(want));
      end
    end
  endtask

  initial begin
    int lat;
    bus.start = 1'b0; bus.dir = DIR_LEFT; bus.a = '0; bus.amt = '0;
    rst_n = 1'b0;
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    run_req("left1",   8'b10101010, DIR_LEFT,  3'd1, 8'b01010100, 2, 0);
    run_req("right3",  8'b00110011, DIR_RIGHT, 3'd3, 8'b00000110, 4, 0);
    run_req("zero",    8'hA5,       DIR_LEFT,  3'd0, 8'hA5,       1, 0);
    run_req("maxl",    8'hFF,       DIR_LEFT,  3'd7, 8'h80,       8, 0);
    run_req("maxr",    8'hFF,       DIR_RIGHT, 3'd7, 8'h01,       8, 0);
    run_req("ignored", 8'h03,       DIR_LEFT,  3'd5, 8'h60,       6, 2);

    // start held high through DONE: second request taken in the next idle cycle
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h81; bus.dir = DIR_RIGHT; bus.amt = 3'd2;
    @(negedge clk);
    bus.a = 8'h03; bus.dir = DIR_LEFT; bus.amt = 3'd1;
    lat = 1;
    while (!bus.done && lat < MAX_WAIT) begin @(negedge clk); lat++; end
    check("held1_lat", 32'(lat), 32'd3);
    check("held1_y", 32'(bus.y), 32'h20);
    @(negedge clk);
    check("held_idle_busy", 32'(bus.busy), 32'd0);
    check("held_idle_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    bus.start = 1'b0;
    check("held2_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("held2_done", 32'(bus.done), 32'd1);
    check("held2_y", 32'(bus.y), 32'h06);

    // reset in the middle of a shift
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hC3; bus.dir = DIR_LEFT; bus.amt = 3'd5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("mid_busy_pre", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_y", 32'(bus.y), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", 32'(bus.done | bus.busy), 32'd0);
    end
    run_req("post_rst", 8'h01, DIR_LEFT, 3'd2, 8'h04, 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
